// File: rtl/icache_pkg.sv
// Shared state type, default cache geometry and address helpers for icache_fetch_resp.
// Address/instruction widths come from `AddrWidth / `InstWidth (default 32).
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

package icache_pkg;

    localparam int ADDR = `AddrWidth;
    localparam int INST = `InstWidth;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_SETS       = 64;

    localparam int BYTE_OFF_W = $clog2(INST / 8);
    localparam int WORD_OFF_W = $clog2(DEF_LINE_WORDS);
    localparam int INDEX_W    = $clog2(DEF_SETS);
    localparam int TAG_W      = ADDR - INDEX_W - WORD_OFF_W - BYTE_OFF_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_REFILL,
        ST_INVAL
    } state_e;

    // Clears the byte and word offset bits, leaving the line base address.
    function automatic logic [ADDR-1:0] line_addr(input logic [ADDR-1:0] pc,
                                                  input int             line_off_w);
        logic [ADDR-1:0] mask;
        mask = '1;
        mask = mask << line_off_w;
        return pc & mask;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped icache: synchronous read of one word
// plus its set's tag and valid bit, one-word write port, per-set and flash valid clear.
module icache_array
    import icache_pkg::*;
#(
    parameter  int LINE_WORDS = DEF_LINE_WORDS,
    parameter  int SETS       = DEF_SETS,
    parameter  int TAG_BITS   = TAG_W,
    localparam int WORD_W     = $clog2(LINE_WORDS),
    localparam int IDX_W      = $clog2(SETS)
) (
    input  logic                clk,
    input  logic                clr_all,
    input  logic                clr_en,
    input  logic [IDX_W-1:0]    clr_idx,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_idx,
    input  logic [WORD_W-1:0]   rd_word,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [INST-1:0]     rd_data,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [WORD_W-1:0]   wr_word,
    input  logic [INST-1:0]     wr_data,
    input  logic                tag_wr_en,
    input  logic [TAG_BITS-1:0] wr_tag
);

    logic [SETS-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_mem  [SETS];
    logic [INST-1:0]     data_mem [SETS*LINE_WORDS];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (clr_all) begin
            valid_q <= '0;
        end else begin
            if (clr_en) begin
                valid_q[clr_idx] <= 1'b0;
            end
            if (tag_wr_en) begin
                valid_q[wr_idx] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data RAMs carry no reset; a line is only trusted through its
    // valid bit, which is the sole thing reset clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_idx, wr_word}] <= wr_data;
        end
        if (tag_wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_all) begin
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= valid_q[rd_idx];
        end
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_idx];
            rd_data <= data_mem[{rd_idx, rd_word}];
        end
    end

endmodule

// File: rtl/icache_fetch_resp.sv
// Direct-mapped read-only instruction cache responder with blocking line refill.
// Optional ICACHE_PERF_EN adds saturating hit/miss counters as outputs.
module icache_fetch_resp
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int SETS       = DEF_SETS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic [ADDR-1:0] fetch_pc,
    input  logic            fetch_flush,
    input  logic            ic_inval,
    output logic            ic_ready,
    output logic            ic_e_,
    output logic [ADDR-1:0] ic_pc,
    output logic [INST-1:0] ic_inst,
    output logic            mem_req,
    output logic [ADDR-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [INST-1:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]     perf_hit,
    output logic [31:0]     perf_miss
`endif
);

    localparam int WORD_W   = $clog2(LINE_WORDS);
    localparam int IDX_W    = $clog2(SETS);
    localparam int LINE_OFF = BYTE_OFF_W + WORD_W;
    localparam int TAG_LW   = ADDR - IDX_W - LINE_OFF;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_SET  = IDX_W'(SETS - 1);

    state_e              state_q, state_d;
    logic [ADDR-1:0]     req_pc_q, req_pc_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]    set_cnt_q, set_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                inval_pend_q, inval_pend_d;
    logic [INST-1:0]     word_buf_q, word_buf_d;
    logic                refill_resp_q, refill_resp_d;
    logic [ADDR-1:0]     resp_pc_q, resp_pc_d;
    logic [INST-1:0]     resp_inst_q, resp_inst_d;

    logic [WORD_W-1:0]   req_word;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_LW-1:0]   req_tag;
    logic                rd_en, wr_en, tag_wr_en, clr_en;
    logic [IDX_W-1:0]    clr_idx;
    logic                rd_valid;
    logic [TAG_LW-1:0]   rd_tag;
    logic [INST-1:0]     rd_data;
    logic                hit, hit_resp, inval_now;

    assign req_word  = req_pc_q[LINE_OFF-1:BYTE_OFF_W];
    assign req_idx   = req_pc_q[LINE_OFF+IDX_W-1:LINE_OFF];
    assign req_tag   = req_pc_q[ADDR-1:LINE_OFF+IDX_W];
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign inval_now = ic_inval || inval_pend_q;

    icache_array #(
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS),
        .TAG_BITS   (TAG_LW)
    ) u_array (
        .clk        (clk),
        .clr_all    (reset),
        .clr_en     (clr_en),
        .clr_idx    (clr_idx),
        .rd_en      (rd_en),
        .rd_idx     (fetch_pc[LINE_OFF+IDX_W-1:LINE_OFF]),
        .rd_word    (fetch_pc[LINE_OFF-1:BYTE_OFF_W]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_idx     (req_idx),
        .wr_word    (word_cnt_q),
        .wr_data    (mem_rdata),
        .tag_wr_en  (tag_wr_en),
        .wr_tag     (req_tag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_pc_q      <= '0;
            word_cnt_q    <= '0;
            set_cnt_q     <= '0;
            flush_pend_q  <= 1'b0;
            inval_pend_q  <= 1'b0;
            word_buf_q    <= '0;
            refill_resp_q <= 1'b0;
            resp_pc_q     <= '0;
            resp_inst_q   <= '0;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            word_cnt_q    <= word_cnt_d;
            set_cnt_q     <= set_cnt_d;
            flush_pend_q  <= flush_pend_d;
            inval_pend_q  <= inval_pend_d;
            word_buf_q    <= word_buf_d;
            refill_resp_q <= refill_resp_d;
            resp_pc_q     <= resp_pc_d;
            resp_inst_q   <= resp_inst_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        word_cnt_d    = word_cnt_q;
        set_cnt_d     = set_cnt_q;
        flush_pend_d  = flush_pend_q;
        inval_pend_d  = inval_pend_q || ic_inval;
        word_buf_d    = word_buf_q;
        refill_resp_d = 1'b0;
        resp_pc_d     = resp_pc_q;
        resp_inst_d   = resp_inst_q;
        ic_ready      = 1'b0;
        mem_req       = 1'b0;
        hit_resp      = 1'b0;
        rd_en         = 1'b0;
        wr_en         = 1'b0;
        tag_wr_en     = 1'b0;
        clr_en        = 1'b0;
        clr_idx       = req_idx;

        unique case (state_q)
            ST_IDLE: begin
                // A fence.i left over from a refill blocks new lookups until it runs.
                ic_ready = !inval_pend_q;
                if (fetch_req && ic_ready) begin
                    state_d = ST_LOOKUP;
                end else if (inval_now) begin
                    state_d      = ST_INVAL;
                    set_cnt_d    = '0;
                    inval_pend_d = 1'b0;
                end
            end
            ST_LOOKUP: begin
                if (fetch_flush || hit) begin
                    hit_resp = hit && !fetch_flush;
                    ic_ready = !inval_now;
                    if (inval_now) begin
                        state_d      = ST_INVAL;
                        set_cnt_d    = '0;
                        inval_pend_d = 1'b0;
                    end else if (fetch_req) begin
                        state_d = ST_LOOKUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    // Once granted the memory will stream the line, so a flush only
                    // suppresses the response from here on.
                    state_d      = ST_REFILL;
                    word_cnt_d   = '0;
                    clr_en       = 1'b1;
                    flush_pend_d = fetch_flush;
                end else if (fetch_flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (fetch_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_rvalid) begin
                    wr_en      = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == req_word) begin
                        word_buf_d = mem_rdata;
                    end
                    if (word_cnt_q == LAST_WORD) begin
                        tag_wr_en    = 1'b1;
                        flush_pend_d = 1'b0;
                        if (!(flush_pend_q || fetch_flush)) begin
                            refill_resp_d = 1'b1;
                            resp_pc_d     = req_pc_q;
                            resp_inst_d   = (word_cnt_q == req_word) ? mem_rdata : word_buf_q;
                        end
                        if (inval_now) begin
                            state_d      = ST_INVAL;
                            set_cnt_d    = '0;
                            inval_pend_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_INVAL: begin
                clr_en       = 1'b1;
                clr_idx      = set_cnt_q;
                set_cnt_d    = set_cnt_q + 1'b1;
                inval_pend_d = 1'b0;
                if (set_cnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (hit_resp) begin
            resp_pc_d   = req_pc_q;
            resp_inst_d = rd_data;
        end
        if (fetch_req && ic_ready) begin
            req_pc_d = fetch_pc;
            rd_en    = 1'b1;
        end
    end

    assign ic_e_    = !(hit_resp || refill_resp_q);
    assign ic_pc    = hit_resp ? req_pc_q : resp_pc_q;
    assign ic_inst  = hit_resp ? rd_data  : resp_inst_q;
    assign mem_addr = line_addr(req_pc_q, LINE_OFF);

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_q, perf_miss_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            if (hit_resp && perf_hit_q != '1) begin
                perf_hit_q <= perf_hit_q + 32'd1;
            end
            if (state_q == ST_MISS_REQ && mem_gnt && perf_miss_q != '1) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_icache_fetch_resp.sv
// Directed bench for icache_fetch_resp: per-cycle vector table plus hand-written
// sequences for invalidate and reset during refill.
module tb_icache_fetch_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, fetch_flush, ic_inval, mem_gnt, mem_rvalid;
    logic [31:0] fetch_pc, mem_rdata;
    logic        ic_ready, ic_e_, mem_req;
    logic [31:0] ic_pc, ic_inst, mem_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    icache_fetch_resp dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_flush (fetch_flush),
        .ic_inval    (ic_inval),
        .ic_ready    (ic_ready),
        .ic_e_       (ic_e_),
        .ic_pc       (ic_pc),
        .ic_inst     (ic_inst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        flush;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        x_ready;
        logic        x_e;
        logic [31:0] x_pc;
        logic [31:0] x_inst;
        logic        x_mreq;
        logic [31:0] x_maddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic req, input logic [31:0] pc, input logic flush,
                                input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                input logic x_ready, input logic x_e, input logic [31:0] x_pc,
                                input logic [31:0] x_inst, input logic x_mreq,
                                input logic [31:0] x_maddr);
        vec_t v;
        v.req = req; v.pc = pc; v.flush = flush; v.gnt = gnt; v.rvalid = rvalid;
        v.rdata = rdata; v.x_ready = x_ready; v.x_e = x_e; v.x_pc = x_pc;
        v.x_inst = x_inst; v.x_mreq = x_mreq; v.x_maddr = x_maddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] pc, input logic flush,
                         input logic inval, input logic gnt, input logic rvalid,
                         input logic [31:0] rdata);
        fetch_req = req; fetch_pc = pc; fetch_flush = flush; ic_inval = inval;
        mem_gnt = gnt; mem_rvalid = rvalid; mem_rdata = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.req, v.pc, v.flush, 1'b0, v.gnt, v.rvalid, v.rdata);
        @(negedge clk);
        check($sformatf("v%0d ic_ready", idx), ic_ready, v.x_ready);
        check($sformatf("v%0d ic_e_", idx), ic_e_, v.x_e);
        if (!v.x_e) begin
            check($sformatf("v%0d ic_pc", idx), ic_pc, v.x_pc);
            check($sformatf("v%0d ic_inst", idx), ic_inst, v.x_inst);
        end
        check($sformatf("v%0d mem_req", idx), mem_req, v.x_mreq);
        if (v.x_mreq) begin
            check($sformatf("v%0d mem_addr", idx), mem_addr, v.x_maddr);
        end
        next_cycle();
    endtask

    initial begin
        int zeros;
        int first_one;

        // Cold miss at 0x100, back-to-back hits.
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0,       1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 1, 0, 0,       0, 1, 0, 0, 1, 32'h100));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hA0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hA1,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hA2,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hA3,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h104, 0, 0, 0, 0,       1, 0, 32'h100, 32'hA0, 0, 0));
        vecs.push_back(mk(1, 32'h108, 0, 0, 0, 0,       1, 0, 32'h104, 32'hA1, 0, 0));
        vecs.push_back(mk(1, 32'h10C, 0, 0, 0, 0,       1, 0, 32'h108, 32'hA2, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       1, 0, 32'h10C, 32'hA3, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       1, 1, 0, 0, 0, 0));
        // Conflict miss 0x500 evicts 0x100; re-fetch of 0x100 misses.
        vecs.push_back(mk(1, 32'h500, 0, 0, 0, 0,       1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 1, 0, 0,       0, 1, 0, 0, 1, 32'h500));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hB0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hB1,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hB2,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hB3,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0,       1, 0, 32'h500, 32'hB0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 1, 0, 0,       0, 1, 0, 0, 1, 32'h100));
        // Flush after the second beat: line installed, no response.
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hA0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hA1,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 1, 32'hA2,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 1, 32'hA3,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h108, 0, 0, 0, 0,       1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       1, 0, 32'h108, 32'hA2, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       1, 1, 0, 0, 0, 0));
        // Flush in MISS_REQ before grant drops mem_req.
        vecs.push_back(mk(1, 32'h900, 0, 0, 0, 0,       1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0, 0,       0, 1, 0, 0, 1, 32'h900));
        vecs.push_back(mk(1, 32'h104, 0, 0, 0, 0,       1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       1, 0, 32'h104, 32'hA1, 0, 0));
        // Flush with a new request during a hit lookup: old response dropped, new one served.
        vecs.push_back(mk(1, 32'h108, 0, 0, 0, 0,       1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h10C, 1, 0, 0, 0,       1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       1, 0, 32'h10C, 32'hA3, 0, 0));
        vecs.push_back(mk(0, 0,       0, 0, 0, 0,       1, 1, 0, 0, 0, 0));

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset ic_e_", ic_e_, 1);
        check("reset ic_ready", ic_ready, 1);
        check("reset ic_pc", ic_pc, 0);
        check("reset ic_inst", ic_inst, 0);
        check("reset mem_req", mem_req, 0);
        check("reset mem_addr", mem_addr, 0);
        next_cycle();
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_vec(vecs[i], i);
        end

        // Invalidate: ready low for exactly SETS cycles starting the next cycle.
        drive(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("inval pulse ic_ready", ic_ready, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        zeros = 0;
        first_one = -1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (!ic_ready) zeros++;
            if (ic_ready && first_one < 0) first_one = c;
            next_cycle();
        end
        check("inval ready-low cycles", zeros, 64);
        check("inval first ready cycle", first_one, 64);

        // 0x100 misses after invalidate; refill with C0..C3.
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("post-inval accept ic_ready", ic_ready, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("post-inval lookup ic_ready", ic_ready, 0);
        check("post-inval lookup ic_e_", ic_e_, 1);
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("post-inval mem_req", mem_req, 1);
        check("post-inval mem_addr", mem_addr, 32'h100);
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            drive(0, 0, 0, 0, 0, 1, 32'hC0 + b);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("post-inval resp ic_e_", ic_e_, 0);
        check("post-inval resp ic_inst", ic_inst, 32'hC0);
        next_cycle();

        // Reset in the middle of a refill of 0x200.
        drive(1, 32'h200, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("rst-refill mem_addr", mem_addr, 32'h200);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 32'hD0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 32'hD1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("after reset mem_req", mem_req, 0);
        check("after reset ic_e_", ic_e_, 1);
        check("after reset ic_ready", ic_ready, 1);
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("after reset 0x100 ic_e_", ic_e_, 1);
        check("after reset 0x100 ic_ready", ic_ready, 0);
        next_cycle();
        drive(0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("after reset 0x100 mem_req", mem_req, 1);
        check("after reset 0x100 mem_addr", mem_addr, 32'h100);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("after flush mem_req", mem_req, 0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
